// File: rtl/hex_display_ctrl.sv
// Multi-digit seven-segment controller: shadowed updates, hex decode, leading-zero
// blanking, PWM dimming and optional per-digit blink (enabled by HEX_DISPLAY_CTRL_BLINK_EN).
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int PWM_BITS   = 4,
  parameter int BLINK_DIV  = 12500000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [4*NUM_DIGITS-1:0]   wr_value,
  input  logic [NUM_DIGITS-1:0]     wr_enable,
  input  logic [NUM_DIGITS-1:0]     wr_blink,
  input  logic                      wr_lzb,
  input  logic [PWM_BITS-1:0]       brightness,
  output logic [7*NUM_DIGITS-1:0]   hex_segs
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    pat = 7'h00;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h67;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return ~pat;
  endfunction

  logic                    r_ready;
  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_enable;
  logic                    r_lzb;
  logic [7*NUM_DIGITS-1:0] r_pattern;
  logic [7*NUM_DIGITS-1:0] r_segs;
  logic [PWM_BITS-1:0]     r_pwm_cnt;

  logic                    w_accept;
  logic [NUM_DIGITS:0]     w_zero_above;
  logic [NUM_DIGITS-1:0]   w_lz_blank;
  logic [7*NUM_DIGITS-1:0] w_pattern_next;
  logic [7*NUM_DIGITS-1:0] w_segs_next;
  logic [NUM_DIGITS-1:0]   w_blink_off;
  logic                    w_pwm_on;

  assign w_accept = wr_valid & r_ready;
  assign wr_ready = r_ready;
  assign hex_segs = r_segs;

  // Ready drops for exactly the cycle after an acceptance; requests then are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ready  <= 1'b1;
      r_value  <= '0;
      r_enable <= '0;
      r_lzb    <= 1'b0;
    end else begin
      r_ready <= ~w_accept;
      if (w_accept) begin
        r_value  <= wr_value;
        r_enable <= wr_enable;
        r_lzb    <= wr_lzb;
      end
    end
  end

`ifdef HEX_DISPLAY_CTRL_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0] r_blink;
  logic [NUM_DIGITS-1:0] r_blink_sel;
  logic [BLINK_W-1:0]    r_blink_cnt;
  logic                  r_blink_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink       <= '0;
      r_blink_sel   <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (w_accept) begin
        r_blink <= wr_blink;
      end
      r_blink_sel <= r_blink;
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign w_blink_off = r_blink_sel & {NUM_DIGITS{r_blink_phase}};
`else
  logic w_unused_blink;
  assign w_unused_blink = ^wr_blink;
  assign w_blink_off    = '0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

  assign w_pwm_on = (&brightness) | (r_pwm_cnt < brightness);

  // Zero-run chain from the most significant digit down drives leading-zero blanking.
  assign w_zero_above[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = NUM_DIGITS - 1; gi >= 0; gi--) begin : g_digit
      assign w_zero_above[gi] = w_zero_above[gi+1] & (r_value[4*gi +: 4] == 4'h0);

      if (gi == 0) begin : g_lsd
        assign w_lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign w_lz_blank[gi] = r_lzb & w_zero_above[gi];
      end

      assign w_pattern_next[7*gi +: 7] = (r_enable[gi] && !w_lz_blank[gi])
                                         ? seg_decode(r_value[4*gi +: 4]) : SEG_BLANK;

      assign w_segs_next[7*gi +: 7] = (w_pwm_on && !w_blink_off[gi])
                                      ? r_pattern[7*gi +: 7] : SEG_BLANK;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pattern <= {NUM_DIGITS{SEG_BLANK}};
      r_segs    <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      r_pattern <= w_pattern_next;
      r_segs    <= w_segs_next;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl (8 digits, 4-bit PWM, blink period 4).
module tb_hex_display_ctrl;

  localparam int ND = 8;
  localparam int PB = 4;
  localparam logic [55:0] ALL_BLANK = {8{7'h7F}};

  logic          clk;
  logic          reset_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [31:0]   wr_value;
  logic [7:0]    wr_enable;
  logic [7:0]    wr_blink;
  logic          wr_lzb;
  logic [3:0]    brightness;
  logic [55:0]   hex_segs;

  int n_tests = 0;
  int n_fail  = 0;

  hex_display_ctrl #(
    .NUM_DIGITS(ND),
    .PWM_BITS  (PB),
    .BLINK_DIV (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_value  (wr_value),
    .wr_enable (wr_enable),
    .wr_blink  (wr_blink),
    .wr_lzb    (wr_lzb),
    .brightness(brightness),
    .hex_segs  (hex_segs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] v, input logic [7:0] en, input logic [7:0] bl,
                       input logic lz);
    wr_value  = v;
    wr_enable = en;
    wr_blink  = bl;
    wr_lzb    = lz;
    wr_valid  = 1'b1;
  endtask

  // Issue one update at a negedge and return at the negedge after edge N+2.
  task automatic upd(input logic [31:0] v, input logic [7:0] en, input logic [7:0] bl,
                     input logic lz);
    drive(v, en, bl, lz);
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [55:0] exp_v1, exp_v3;
  int lit_cnt, blank_cnt, d0_cnt, d1_cnt, n_bad;
  logic [15:0] d0_lit;

  initial begin
    reset_n    = 1'b0;
    wr_valid   = 1'b0;
    wr_value   = '0;
    wr_enable  = '0;
    wr_blink   = '0;
    wr_lzb     = 1'b0;
    brightness = 4'hF;
    repeat (3) @(negedge clk);
    check("reset_segs", 64'(hex_segs), 64'(ALL_BLANK));
    check("reset_ready", 64'(wr_ready), 64'd1);

    // Release and accept on the very first edge afterwards
    reset_n = 1'b1;
    drive(32'h0123ABCD, 8'hFF, 8'h00, 1'b0);
    @(negedge clk);
    check("ready_low_after_accept", 64'(wr_ready), 64'd0);
    check("latency_n1_blank", 64'(hex_segs), 64'(ALL_BLANK));
    wr_valid = 1'b0;
    @(negedge clk);
    check("ready_back_high", 64'(wr_ready), 64'd1);
    check("latency_n2_blank", 64'(hex_segs), 64'(ALL_BLANK));
    @(negedge clk);
    check("decode_0123ABCD", 64'(hex_segs),
          64'({7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}));

    upd(32'h000000A0, 8'hFF, 8'h00, 1'b1);
    check("lzb_A0", 64'(hex_segs), 64'({{6{7'h7F}}, 7'h08, 7'h40}));
    upd(32'h00000000, 8'hFF, 8'h00, 1'b1);
    check("lzb_zero", 64'(hex_segs), 64'({{7{7'h7F}}, 7'h40}));
    upd(32'h00F00E09, 8'hFF, 8'h00, 1'b1);
    check("lzb_inner_zeros", 64'(hex_segs),
          64'({7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h06, 7'h40, 7'h18}));
    upd(32'h00F00E09, 8'hFF, 8'h00, 1'b0);
    check("no_lzb_zeros_shown", 64'(hex_segs),
          64'({7'h40, 7'h40, 7'h0E, 7'h40, 7'h40, 7'h06, 7'h40, 7'h18}));
    upd(32'h12345678, 8'h0F, 8'h00, 1'b0);
    check("enable_mask", 64'(hex_segs), 64'({{4{7'h7F}}, 7'h12, 7'h02, 7'h78, 7'h00}));

    // Valid held for 4 cycles: only cycles 1 and 3 are accepted
    exp_v1 = {8{7'h79}};
    exp_v3 = {8{7'h30}};
    drive(32'h11111111, 8'hFF, 8'h00, 1'b0);
    @(negedge clk);
    check("hs_ready_c1", 64'(wr_ready), 64'd0);
    wr_value = 32'h22222222;
    @(negedge clk);
    check("hs_ready_c2", 64'(wr_ready), 64'd1);
    wr_value = 32'h33333333;
    @(negedge clk);
    check("hs_ready_c3", 64'(wr_ready), 64'd0);
    check("hs_segs_v1_a", 64'(hex_segs), 64'(exp_v1));
    wr_value = 32'h44444444;
    @(negedge clk);
    check("hs_ready_c4", 64'(wr_ready), 64'd1);
    check("hs_segs_v1_b", 64'(hex_segs), 64'(exp_v1));
    wr_valid = 1'b0;
    @(negedge clk);
    check("hs_segs_v3", 64'(hex_segs), 64'(exp_v3));
    @(negedge clk);
    check("hs_v4_dropped", 64'(hex_segs), 64'(exp_v3));

    // PWM duty over a 16-cycle window
    brightness = 4'h4;
    @(negedge clk);
    lit_cnt = 0; blank_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (hex_segs === exp_v3) lit_cnt++;
      if (hex_segs === ALL_BLANK) blank_cnt++;
      @(negedge clk);
    end
    check("pwm4_lit", 64'(lit_cnt), 64'd4);
    check("pwm4_blank", 64'(blank_cnt), 64'd12);
    brightness = 4'h0;
    @(negedge clk);
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (hex_segs !== ALL_BLANK) lit_cnt++;
      @(negedge clk);
    end
    check("pwm0_lit", 64'(lit_cnt), 64'd0);
    brightness = 4'hF;
    @(negedge clk);
    lit_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (hex_segs === exp_v3) lit_cnt++;
      @(negedge clk);
    end
    check("pwmF_lit", 64'(lit_cnt), 64'd16);

    // Blink select on digit 0 only; both digits show '8' (all segments on)
    upd(32'h00000088, 8'h03, 8'h01, 1'b0);
    d0_cnt = 0; d1_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      d0_lit[i] = (hex_segs[6:0] === 7'h00);
      if (hex_segs[6:0] === 7'h00) d0_cnt++;
      if (hex_segs[13:7] === 7'h00) d1_cnt++;
      @(negedge clk);
    end
    check("blink_d1_steady", 64'(d1_cnt), 64'd16);
`ifdef HEX_DISPLAY_CTRL_BLINK_EN
    check("blink_d0_half", 64'(d0_cnt), 64'd8);
    n_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (d0_lit[i] == d0_lit[i+4]) n_bad++;
    end
    check("blink_d0_period", 64'(n_bad), 64'd0);
`else
    check("blink_d0_steady", 64'(d0_cnt), 64'd16);
`endif

    // Asynchronous reset while an update is in flight
    drive(32'h00000005, 8'hFF, 8'h00, 1'b0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_segs", 64'(hex_segs), 64'(ALL_BLANK));
    check("async_reset_ready", 64'(wr_ready), 64'd1);
    wr_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("inflight_discarded", 64'(hex_segs), 64'(ALL_BLANK));
    upd(32'h0000000C, 8'h01, 8'h00, 1'b0);
    check("post_reset_update", 64'(hex_segs), 64'({{7{7'h7F}}, 7'h46}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
